// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: multi-cycle register-file read/issue/writeback sequencer with retire counter
module regfile_access_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [4:0]       A1,
  output logic [4:0]       A2,
  input  logic [XLEN-1:0]  RD1,
  input  logic [XLEN-1:0]  RD2,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [XLEN-1:0]  op_a,
  output logic [XLEN-1:0]  op_b,
  input  logic             res_valid,
  input  logic             res_wen,
  input  logic [XLEN-1:0]  res_data,
  output logic [4:0]       A3,
  output logic [XLEN-1:0]  WD3,
  output logic             WE3,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WB} state_t;
  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, wd_q, wd_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  // next-state and datapath capture for each phase of one instruction
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wd_d    = wd_q;
    ret_d   = ret_q;
    case (state_q)
      IDLE: if (instr_valid) begin
        instr_d = instr;
        state_d = READ;
      end
      READ: begin
        op_a_d  = RD1;
        op_b_d  = RD2;
        state_d = ISSUE;
      end
      ISSUE: state_d = op_ready ? WAIT : ISSUE;
      WAIT: if (res_valid) begin
        if (res_wen && instr_q[11:7] != 5'd0) begin
          wd_d    = res_data;
          state_d = WB;
        end else begin
          ret_d   = ret_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      WB: begin
        ret_d   = ret_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset discards any in-flight instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      wd_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      wd_q    <= wd_d;
      ret_q   <= ret_d;
    end
  end
  assign instr_ready = state_q == IDLE;
  assign op_valid    = state_q == ISSUE;
  assign WE3         = state_q == WB;
  assign A1          = instr_q[19:15];
  assign A2          = instr_q[24:20];
  assign A3          = instr_q[11:7];
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign WD3         = wd_q;
  assign retired     = ret_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed vector bench with a behavioural register file
module tb_regfile_access_ctrl;
  logic        clk = 0, reset = 0;
  logic        instr_valid = 0, op_ready = 0, res_valid = 0, res_wen = 0;
  logic [31:0] instr = 0, res_data = 0, RD1, RD2;
  logic        instr_ready, op_valid, WE3;
  logic [4:0]  A1, A2, A3;
  logic [31:0] op_a, op_b, WD3;
  logic [15:0] retired;
  logic        instr_ready4, op_valid4, WE3_4;
  logic [4:0]  A1_4, A2_4, A3_4;
  logic [31:0] op_a4, op_b4, WD3_4;
  logic [3:0]  retired4;
  logic [31:0] rf [32];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_wen(res_wen), .res_data(res_data),
    .A3(A3), .WD3(WD3), .WE3(WE3), .retired(retired));

  regfile_access_ctrl #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready4),
    .A1(A1_4), .A2(A2_4), .RD1(RD1), .RD2(RD2), .op_valid(op_valid4), .op_ready(op_ready),
    .op_a(op_a4), .op_b(op_b4), .res_valid(res_valid), .res_wen(res_wen), .res_data(res_data),
    .A3(A3_4), .WD3(WD3_4), .WE3(WE3_4), .retired(retired4));

  assign RD1 = rf[A1];
  assign RD2 = rf[A2];
  always @(negedge clk) if (WE3 && A3 != 5'd0) rf[A3] <= WD3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        wen;
    logic [31:0] data;
    int          stall;
    logic        spur;
    logic [4:0]  ea1, ea2;
    logic [31:0] ea, eb;
    int          ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
  } vec_t;

  task automatic run(input logic [31:0] ins, input logic wen, input logic [31:0] data,
                     input int stall, input logic spur,
                     output logic [4:0] a1, output logic [4:0] a2, output logic [31:0] a,
                     output logic [31:0] b, output int we_cnt, output logic [4:0] wa,
                     output logic [31:0] wd);
    we_cnt = 0; wa = 0; wd = 0;
    for (int k = 0; k < 20 && !instr_ready; k++) @(negedge clk);
    if (!instr_ready) chk("ready_timeout", 0, 1);
    instr_valid = 1; instr = ins;
    @(posedge clk); #1 instr_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("op_valid_issue", op_valid, 1);
    a1 = A1; a2 = A2; a = op_a; b = op_b;
    for (int s = 0; s < stall; s++) begin
      chk("stall_op_valid", op_valid, 1);
      chk("stall_op_a", op_a, a);
      chk("stall_op_b", op_b, b);
      @(negedge clk);
    end
    op_ready = 1;
    @(posedge clk); #1 op_ready = 0;
    @(negedge clk);
    chk("op_valid_drop", op_valid, 0);
    if (spur) begin
      instr_valid = 1; instr = 32'h00428333;
      for (int s = 0; s < 2; s++) begin
        @(negedge clk);
        chk("spur_ready", instr_ready, 0);
        chk("spur_a1", A1, a1);
      end
      instr_valid = 0;
    end
    res_valid = 1; res_wen = wen; res_data = data;
    @(posedge clk); #1 res_valid = 0; res_wen = 0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      if (WE3) begin we_cnt++; wa = A3; wd = WD3; end
    end
  endtask

  vec_t v [5];
  logic [4:0]  g1, g2, gwa;
  logic [31:0] ga, gb, gwd;
  int          gwe;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 0;
    rf[1] = 5; rf[2] = 7;
    v[0] = '{32'h002081B3, 1, 32'd12,        0, 0, 1, 2, 5,            7,  1, 3, 12};
    v[1] = '{32'h00208033, 1, 32'd99,        0, 0, 1, 2, 5,            7,  0, 0, 0};
    v[2] = '{32'h00118233, 1, 32'd17,        4, 1, 3, 1, 12,           5,  1, 4, 17};
    v[3] = '{32'h000002B3, 1, 32'hDEADBEEF,  0, 0, 0, 0, 0,            0,  1, 5, 32'hDEADBEEF};
    v[4] = '{32'h00428333, 0, 32'd1,         0, 0, 5, 4, 32'hDEADBEEF, 17, 0, 0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_we3", WE3, 0);
    chk("rst_retired", retired, 0);
    chk("rst_addr", {A1, A2, A3}, 0);
    chk("rst_ops", {op_a, op_b}, 0);
    chk("rst_wd3", WD3, 0);
    reset = 1;
    @(negedge clk);
    chk("rel_instr_ready", instr_ready, 1);
    for (int i = 0; i < 5; i++) begin
      run(v[i].ins, v[i].wen, v[i].data, v[i].stall, v[i].spur, g1, g2, ga, gb, gwe, gwa, gwd);
      chk($sformatf("v%0d_a1", i), g1, v[i].ea1);
      chk($sformatf("v%0d_a2", i), g2, v[i].ea2);
      chk($sformatf("v%0d_op_a", i), ga, v[i].ea);
      chk($sformatf("v%0d_op_b", i), gb, v[i].eb);
      chk($sformatf("v%0d_we_cnt", i), gwe, v[i].ewe);
      if (v[i].ewe != 0) begin
        chk($sformatf("v%0d_a3", i), gwa, v[i].ewa);
        chk($sformatf("v%0d_wd3", i), gwd, v[i].ewd);
      end
      chk($sformatf("v%0d_retired", i), retired, i + 1);
    end
    chk("rf_x3", rf[3], 12);
    chk("rf_x4", rf[4], 17);
    chk("rf_x5", rf[5], 32'hDEADBEEF);
    chk("rf_x0", rf[0], 0);
    chk("retired4_5", retired4, 5);
    // results and op_ready presented while idle must be ignored
    res_valid = 1; res_wen = 1; res_data = 32'h77; op_ready = 1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("idle_ready", instr_ready, 1);
      chk("idle_we3", WE3, 0);
      chk("idle_op_valid", op_valid, 0);
    end
    res_valid = 0; res_wen = 0; op_ready = 0;
    chk("idle_retired", retired, 5);
    // reset asserted while the writeback pulse is active
    instr_valid = 1; instr = 32'h002081B3;
    @(posedge clk); #1 instr_valid = 0;
    @(posedge clk); #1 op_ready = 1;
    @(posedge clk); #1 op_ready = 0; res_valid = 1; res_wen = 1; res_data = 32'h55;
    @(posedge clk); #1 res_valid = 0; res_wen = 0;
    chk("wb_we3", WE3, 1);
    reset = 0;
    #1;
    chk("arst_we3", WE3, 0);
    chk("arst_op_valid", op_valid, 0);
    chk("arst_retired", retired, 0);
    chk("arst_retired4", retired4, 0);
    @(negedge clk);
    chk("arst_no_write", rf[3], 12);
    reset = 1;
    @(negedge clk);
    chk("arst_rel_ready", instr_ready, 1);
    chk("arst_rel_a3", A3, 0);
    // seventeen retirements wrap the 4-bit counter
    for (int i = 0; i < 17; i++)
      run(32'h00208033, 0, 0, 0, 0, g1, g2, ga, gb, gwe, gwa, gwd);
    chk("ret17_16bit", retired, 17);
    chk("ret17_4bit", retired4, 1);
    chk("x0_still_zero", rf[0], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Multi-cycle initiator for the 32x32 register file (read ports A1/RD1, A2/RD2; write port A3/WD3/WE3, captured on negedge clk, writes to x0 ignored). Accepts one RV32 instruction word at a time and drives the source-register reads. Hands the captured operands to the execute stage and waits for its result. Drives the single-cycle writeback pulse and counts retired instructions.

Parameters:
XLEN, 32, data width of operands, result and register-file data ports
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
instr_valid  input  1  fetch presents instruction
instr  input  32  RV32 instruction word
instr_ready  output  1  controller accepts instruction
A1  output  5  register-file read address 1 (rs1)
A2  output  5  register-file read address 2 (rs2)
RD1  input  XLEN  register-file read data 1
RD2  input  XLEN  register-file read data 2
op_valid  output  1  operands valid to execute stage
op_ready  input  1  execute stage accepts operands
op_a  output  XLEN  captured rs1 value
op_b  output  XLEN  captured rs2 value
res_valid  input  1  execute result present
res_wen  input  1  instruction writes rd
res_data  input  XLEN  result value
A3  output  5  register-file write address
WD3  output  XLEN  register-file write data
WE3  output  1  register-file write enable
retired  output  CNT_W  completed-instruction count

Behaviour:
- States: IDLE, READ, ISSUE, WAIT, WB. All outputs come from registers or decode of the state register only; no combinational path from any input to any output.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - instr register, A1, A2, A3, op_a, op_b, WD3 = 0.
  - WE3=0, op_valid=0, retired=0.
  - instr_ready=1 once reset is released.
- IDLE:
  - instr_ready=1.
  - On instr_valid: latch instr. A1<=instr[19:15], A2<=instr[24:20], A3<=instr[11:7]. Go to READ.
- READ (exactly 1 cycle):
  - A1/A2 are stable for this whole cycle.
  - At the closing edge: op_a<=RD1, op_b<=RD2. Go to ISSUE.
- ISSUE:
  - op_valid=1. op_a/op_b hold.
  - Handshake completes on the edge where op_valid&op_ready; then go to WAIT.
  - op_ready may already be high on the first ISSUE cycle (1-cycle ISSUE).
- WAIT:
  - On res_valid with res_wen=1 and A3!=0: WD3<=res_data, go to WB.
  - On res_valid with res_wen=0 or A3==0: retired<=retired+1, go to IDLE. No write is issued.
- WB (exactly 1 cycle):
  - WE3=1 with A3/WD3 stable, so the register file captures on that cycle's negedge.
  - retired<=retired+1, go to IDLE.
- Latency:
  - Accept at edge 0; op_valid high from cycle 2.
  - res_valid sampled at edge n → WE3 high in cycle n+1 → instr_ready high in cycle n+2.
  - Back-to-back read-after-write is safe: the write lands at the WB negedge, before the next READ.
- Ignored inputs: instr_valid outside IDLE, res_valid outside WAIT, op_ready outside ISSUE.
- A1/A2/A3 hold their values until the next accept.
- retired wraps from 2^CNT_W−1 to 0 silently.
- Reset asserted mid-operation:
  - WE3 and op_valid drop immediately.
  - No partial write occurs unless the negedge already passed.
  - The in-flight instruction is discarded and not counted.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3) with regfile x1=5, x2=7, op_ready=1, res_data=12, res_wen=1 → A1=1, A2=2, op_a=5, op_b=7, WE3 pulse 1 cycle with A3=3/WD3=12, x3 reads 12, retired=1.
- Instruction with rd=x0 (0x00208033), res_wen=1 → WE3 never asserts; retired increments; x0 still 0.
- op_ready held low 4 cycles in ISSUE → op_valid, op_a, op_b stable for all 4 cycles; exactly one transfer follows.
- Back-to-back: write x5=0xDEADBEEF, then an instruction with rs1=x5 → second op_a=0xDEADBEEF.
- instr_valid and res_valid pulsed in the wrong states → no state change and no spurious WE3.
- reset=0 asserted during WB → WE3=0 asynchronously, retired=0; after release, state is IDLE with instr_ready=1.
- CNT_W=4, 17 retirements → retired=1.
